// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one single-outstanding memory port.
// Optional macro ARB_ROUND_ROBIN_EN: ties alternate; otherwise load/store wins every tie.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  output logic [DW-1:0] ls_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          sel,
  output logic [1:0]    dbg_state
);

  // Handshake: a requester holds req and its payload until it sees gnt for one
  // cycle; the response arrives later as a single-cycle rvalid with rdata.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2
  } state_t;

  state_t state, state_next;
  logic   sel_q, sel_next;
  logic   grant_if, grant_ls;
  logic   ls_wins_tie;

`ifdef ARB_ROUND_ROBIN_EN
  // last_ls: 1 when the most recent grant went to load/store.
  logic last_ls;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_ls <= 1'b1;
    end else if (grant_if || grant_ls) begin
      last_ls <= grant_ls;
    end
  end

  assign ls_wins_tie = !last_ls;
`else
  assign ls_wins_tie = 1'b1;
`endif

  always_comb begin
    state_next = state;
    grant_if   = 1'b0;
    grant_ls   = 1'b0;
    if_rvalid  = 1'b0;
    ls_rvalid  = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          grant_ls = ls_req && (!if_req || ls_wins_tie);
          grant_if = if_req && !grant_ls;
        end
        if (grant_ls) begin
          state_next = BUSY_LS;
        end else if (grant_if) begin
          state_next = BUSY_IF;
        end
      end
      BUSY_IF: begin
        if (mem_rvalid) begin
          if_rvalid  = !rst;
          state_next = IDLE;
        end
      end
      BUSY_LS: begin
        if (mem_rvalid) begin
          ls_rvalid  = !rst;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The select only moves on a grant; busy cycles and idle gaps keep the owner.
  assign sel_next  = grant_ls ? 1'b1 : (grant_if ? 1'b0 : sel_q);
  assign sel       = sel_next;
  assign if_gnt    = grant_if;
  assign ls_gnt    = grant_ls;
  assign mem_req   = grant_if || grant_ls;
  assign mem_we    = grant_ls && ls_we;
  assign mem_addr  = sel_next ? ls_addr : if_addr;
  assign mem_wdata = sel_next ? ls_wdata : '0;
  assign if_rdata  = mem_rdata;
  assign ls_rdata  = mem_rdata;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel_q <= 1'b0;
    end else begin
      state <= state_next;
      sel_q <= sel_next;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: reset, fetch, store, tie-break order,
// blocking while busy, reset abandonment and stray memory responses.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          ls_req, ls_we;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ls_gnt, ls_rvalid;
  logic [DW-1:0] ls_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          sel;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .sel(sel), .dbg_state(dbg_state)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_addr = '0;
    ls_wdata = '0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; if_req = 1; ls_req = 1; mem_rvalid = 1;
    tick(); tick();
    #1;
    checks++;
    if ({if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_req} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs: got %b required 00000", {if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_req});
    end
    checks++;
    if ({dbg_state, sel} !== 3'b000) begin
      errors++; $display("FAIL reset_state_sel: got %b required 000", {dbg_state, sel});
    end
    idle_inputs();
    rst = 0;
    tick();
  endtask

  task automatic test_fetch();
    do_reset();
    if_req = 1; if_addr = 32'h100;
    #1;
    checks++;
    if ({if_gnt, ls_gnt, mem_req, mem_we, sel} !== 5'b10100 || mem_addr !== 32'h100) begin
      errors++; $display("FAIL fetch_grant: got gnt/req/we/sel=%b addr=%h required 10100 addr=00000100", {if_gnt, ls_gnt, mem_req, mem_we, sel}, mem_addr);
    end
    tick();
    if_req = 0;
    #1;
    checks++;
    if ({dbg_state, if_gnt, ls_gnt, mem_req, sel} !== 6'b010000) begin
      errors++; $display("FAIL fetch_busy: got %b required 010000", {dbg_state, if_gnt, ls_gnt, mem_req, sel});
    end
    mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if ({if_rvalid, ls_rvalid} !== 2'b10 || if_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL fetch_resp: got rvalid=%b rdata=%h required 10 deadbeef", {if_rvalid, ls_rvalid}, if_rdata);
    end
    tick();
    mem_rvalid = 0;
    #1;
    checks++;
    if ({dbg_state, sel, if_rvalid} !== 4'b0000) begin
      errors++; $display("FAIL fetch_idle: got %b required 0000", {dbg_state, sel, if_rvalid});
    end
  endtask

  task automatic test_store();
    do_reset();
    ls_req = 1; ls_we = 1; ls_addr = 32'h200; ls_wdata = 32'h12345678;
    #1;
    checks++;
    if ({if_gnt, ls_gnt, mem_req, mem_we, sel} !== 5'b01111 || mem_addr !== 32'h200 || mem_wdata !== 32'h12345678) begin
      errors++; $display("FAIL store_grant: got %b addr=%h wdata=%h required 01111 00000200 12345678", {if_gnt, ls_gnt, mem_req, mem_we, sel}, mem_addr, mem_wdata);
    end
    tick();
    ls_req = 0; ls_we = 0;
    mem_rvalid = 1; mem_rdata = 32'h0;
    #1;
    checks++;
    if ({dbg_state, ls_rvalid, if_rvalid, sel} !== 5'b10101) begin
      errors++; $display("FAIL store_ack: got %b required 10101", {dbg_state, ls_rvalid, if_rvalid, sel});
    end
    tick();
    mem_rvalid = 0;
    #1;
    // sel keeps pointing at load/store while idle.
    checks++;
    if ({dbg_state, sel, mem_req, mem_we} !== 5'b00100) begin
      errors++; $display("FAIL store_idle_sel_hold: got %b required 00100", {dbg_state, sel, mem_req, mem_we});
    end
  endtask

  task automatic test_tie_order();
    logic [3:0] exp_ls;
`ifdef ARB_ROUND_ROBIN_EN
    exp_ls = 4'b1010;
`else
    exp_ls = 4'b1111;
`endif
    do_reset();
    if_req = 1; if_addr = 32'h300; ls_req = 1; ls_we = 0; ls_addr = 32'h400;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({if_gnt, ls_gnt, mem_req, sel} !== {!exp_ls[i], exp_ls[i], 1'b1, exp_ls[i]}
          || mem_addr !== (exp_ls[i] ? 32'h400 : 32'h300)) begin
        errors++; $display("FAIL tie_grant_%0d: got gnt_if/gnt_ls/req/sel=%b addr=%h required ls_wins=%b", i, {if_gnt, ls_gnt, mem_req, sel}, mem_addr, exp_ls[i]);
      end
      tick();
      mem_rvalid = 1; mem_rdata = 32'hA0 + i;
      #1;
      checks++;
      if ({if_gnt, ls_gnt, mem_req, if_rvalid, ls_rvalid} !== {3'b000, !exp_ls[i], exp_ls[i]} || ls_rdata !== 32'hA0 + i) begin
        errors++; $display("FAIL tie_resp_%0d: got %b rdata=%h required ls_wins=%b", i, {if_gnt, ls_gnt, mem_req, if_rvalid, ls_rvalid}, ls_rdata, exp_ls[i]);
      end
      tick();
      mem_rvalid = 0;
    end
    idle_inputs();
  endtask

  task automatic test_busy_block();
    do_reset();
    if_req = 1; if_addr = 32'h500;
    #1;
    checks++;
    if (if_gnt !== 1'b1) begin
      errors++; $display("FAIL block_if_gnt: got %b required 1", if_gnt);
    end
    tick();
    if_req = 0; ls_req = 1; ls_we = 0; ls_addr = 32'h600;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({ls_gnt, if_gnt, mem_req, sel, dbg_state} !== 6'b000001) begin
        errors++; $display("FAIL block_wait_%0d: got %b required 000001", i, {ls_gnt, if_gnt, mem_req, sel, dbg_state});
      end
      tick();
    end
    mem_rvalid = 1; mem_rdata = 32'h55AA55AA;
    #1;
    checks++;
    if ({if_rvalid, ls_rvalid, ls_gnt} !== 3'b100 || if_rdata !== 32'h55AA55AA) begin
      errors++; $display("FAIL block_resp: got %b rdata=%h required 100 55aa55aa", {if_rvalid, ls_rvalid, ls_gnt}, if_rdata);
    end
    tick();
    mem_rvalid = 0;
    #1;
    checks++;
    if ({ls_gnt, mem_req, sel} !== 3'b111 || mem_addr !== 32'h600) begin
      errors++; $display("FAIL block_ls_gnt_after: got %b addr=%h required 111 00000600", {ls_gnt, mem_req, sel}, mem_addr);
    end
    tick();
    ls_req = 0;
    mem_rvalid = 1;
    tick();
    mem_rvalid = 0;
  endtask

  task automatic test_reset_abandon();
    do_reset();
    ls_req = 1; ls_we = 0; ls_addr = 32'h700;
    tick();
    ls_req = 0;
    #1;
    checks++;
    if (dbg_state !== 2'd2) begin
      errors++; $display("FAIL abandon_busy_ls: got state=%0d required 2", dbg_state);
    end
    rst = 1;
    tick();
    rst = 0; mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
    #1;
    checks++;
    if ({ls_rvalid, if_rvalid, dbg_state} !== 4'b0000) begin
      errors++; $display("FAIL abandon_resp: got %b required 0000", {ls_rvalid, if_rvalid, dbg_state});
    end
    tick();
    mem_rvalid = 0;
  endtask

  task automatic test_idle_rvalid();
    do_reset();
    mem_rvalid = 1; mem_rdata = 32'h13579BDF;
    #1;
    checks++;
    if ({if_rvalid, ls_rvalid, if_gnt, ls_gnt, mem_req} !== 5'b0) begin
      errors++; $display("FAIL idle_rvalid: got %b required 00000", {if_rvalid, ls_rvalid, if_gnt, ls_gnt, mem_req});
    end
    tick();
    mem_rvalid = 0;
    #1;
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++; $display("FAIL idle_rvalid_state: got %0d required 0", dbg_state);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_fetch();
    test_store();
    test_tie_order();
    test_busy_block();
    test_reset_abandon();
    test_idle_rvalid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, meaning address width.
REQ-002 SHALL have parameter DW, default 32, meaning data width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port if_req  input  1  fetch-side request; held with if_addr until if_gnt.
REQ-006 SHALL have port if_addr  input  AW  fetch address.
REQ-007 SHALL have port if_gnt  output  1  fetch request accepted this cycle.
REQ-008 SHALL have port if_rvalid  output  1  fetch response valid, one cycle.
REQ-009 SHALL have port if_rdata  output  DW  fetch read data.
REQ-010 SHALL have port ls_req  input  1  load/store request; held with ls_we/ls_addr/ls_wdata until ls_gnt.
REQ-011 SHALL have port ls_we  input  1  1 = store, 0 = load.
REQ-012 SHALL have port ls_addr  input  AW  load/store address.
REQ-013 SHALL have port ls_wdata  input  DW  store data.
REQ-014 SHALL have port ls_gnt  output  1  load/store request accepted this cycle.
REQ-015 SHALL have port ls_rvalid  output  1  load data or store acknowledge, one cycle.
REQ-016 SHALL have port ls_rdata  output  DW  load read data.
REQ-017 SHALL have port mem_req  output  1  memory request strobe, one cycle per transaction.
REQ-018 SHALL have port mem_we  output  1  memory write enable.
REQ-019 SHALL have port mem_addr  output  AW  memory address.
REQ-020 SHALL have port mem_wdata  output  DW  memory write data.
REQ-021 SHALL have port mem_rvalid  input  1  memory response (read data or write ack).
REQ-022 SHALL have port mem_rdata  input  DW  memory read data.
REQ-023 SHALL have port sel  output  1  shared-port mux select: 0 = fetch, 1 = load/store.

Function
REQ-024 SHALL implement FSM states IDLE, BUSY_IF and BUSY_LS.
REQ-025 In IDLE with at least one request, SHALL combinationally assert exactly one gnt plus mem_req, drive sel/mem_* from the winner, and enter BUSY_<winner> at the next edge.
REQ-026 Single requester SHALL always win; if_req and ls_req together SHALL be resolved per REQ-036/037.
REQ-027 In BUSY states, SHALL hold sel at the owner, keep mem_req, if_gnt and ls_gnt at 0, and ignore new requests.
REQ-028 In BUSY_x, mem_rvalid=1 SHALL produce x_rvalid=1 with x_rdata=mem_rdata in the same cycle (combinational), return to IDLE at the next edge.
REQ-029 The non-owner rvalid SHALL stay 0; mem_rvalid in IDLE SHALL be ignored.
REQ-030 Stores SHALL complete via mem_rvalid exactly like loads; ls_rvalid acknowledges them; fetches always drive mem_we=0.
REQ-031 Outstanding transactions SHALL be at most one; minimum spacing between grants is 2 cycles (grant, response, next grant in IDLE).
REQ-032 In IDLE with no request, mem_req=0, mem_we=0 and sel SHALL hold its last value.
REQ-033 if_rdata and ls_rdata SHALL equal mem_rdata whenever their rvalid is 1; value otherwise don't-care.

Reset
REQ-034 rst=1 at a rising edge SHALL force IDLE, sel=0 and last-grant pointer=load/store; all gnt, rvalid and mem_req outputs SHALL be 0 while rst=1.
REQ-035 Reset mid-transaction SHALL abandon it: a later mem_rvalid SHALL produce no rvalid to either requester.

Configuration
REQ-036 With macro ARB_ROUND_ROBIN_EN defined, a tie SHALL go to the requester not granted last; the pointer updates on each grant.
REQ-037 Without ARB_ROUND_ROBIN_EN, a tie SHALL always go to load/store (fixed priority); the pointer logic is absent.

Verification
REQ-038 Reset, if_req=1 at 0x100 alone -> same cycle if_gnt=1, mem_addr=0x100, sel=0; mem_rvalid with 0xDEADBEEF -> if_rvalid=1, if_rdata=0xDEADBEEF.
REQ-039 ls store 0x200/0x12345678 -> ls_gnt, mem_we=1, mem_wdata=0x12345678, sel=1; mem_rvalid -> ls_rvalid=1, if_rvalid=0.
REQ-040 Both requests held for 4 grants, ARB_ROUND_ROBIN_EN defined -> order IF, LS, IF, LS; undefined -> LS, LS, LS, LS.
REQ-041 ls_req raised while BUSY_IF with response delayed 3 cycles -> no ls_gnt until the cycle after if_rvalid.
REQ-042 rst pulsed in BUSY_LS, mem_rvalid next cycle -> ls_rvalid=0, if_rvalid=0, state IDLE.
REQ-043 mem_rvalid=1 in IDLE with no request -> both rvalid stay 0, no gnt.
